// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Host-push / Uart8-handshake bundle for the uart_tx_fifo buffer.
//            The slave view is the FIFO itself. The master view is the
//            surrounding logic, meaning the host writer plus the Uart8 side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    // host push side
    logic              wrEn;
    logic [7:0]        wrData;
    logic              flush;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              sent;
    // Uart8 side
    logic              txStart;
    logic [7:0]        txByte;
    logic              txBusy;
    logic              txDone;

    modport slave (
        input  wrEn, wrData, flush, txBusy, txDone,
        output full, empty, count, overflow, sent, txStart, txByte
    );

    modport master (
        output wrEn, wrData, flush, txBusy, txDone,
        input  full, empty, count, overflow, sent, txStart, txByte
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Circular byte queue in front of a Uart8 transmitter. It issues
//            exactly one txStart per popped byte through the txBusy/txDone
//            handshake, so queued bytes go out back to back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  wire            clk,
    input  wire            rstN,
    uart_tx_fifo_if.slave  bus
);
    localparam int              ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic               r_sent;
    logic               r_tx_start;
    logic [7:0]         r_tx_byte;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_can_pop;
    logic               w_pop;
    logic               w_sent_next;
    logic               w_tx_start_next;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    // Flush wins over both a push and a pop in the same cycle.
    assign w_push    = bus.wrEn && !w_full && !bus.flush;
    assign w_can_pop = !w_empty && !bus.txBusy && !bus.flush;

    // Next-state / handshake decode; a finished frame may hand straight over to the next pop.
    always_comb begin
        w_state_next    = r_state;
        w_pop           = 1'b0;
        w_sent_next     = 1'b0;
        w_tx_start_next = r_tx_start;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop           = 1'b1;
                    w_tx_start_next = 1'b1;
                    w_state_next    = S_START;
                end
            end
            S_START: begin
                // Hold txStart until the UART accepts it; it may be disabled for a long time.
                if (bus.flush) begin
                    w_tx_start_next = 1'b0;
                    w_state_next    = S_IDLE;
                end else if (bus.txBusy) begin
                    w_tx_start_next = 1'b0;
                    w_state_next    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A flush here does not abort the frame already on the wire.
                if (bus.txDone || !bus.txBusy) begin
                    w_sent_next = 1'b1;
                    if (w_can_pop) begin
                        w_pop           = 1'b1;
                        w_tx_start_next = 1'b1;
                        w_state_next    = S_START;
                    end else begin
                        w_state_next    = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_start_next = 1'b0;
                w_state_next    = S_IDLE;
            end
        endcase
    end

    // FSM state and handshake output registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_sent     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_tx_start_next;
            r_sent     <= w_sent_next;
        end
    end

    // Queue bookkeeping: pointers, occupancy, sticky overflow and the byte in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            if (bus.flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + C_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - C_CNT_ONE;
                end
                if (bus.wrEn && w_full) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr];
            end
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wrData;
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.sent     = r_sent;
    assign bus.txStart  = r_tx_start;
    assign bus.txByte   = r_tx_byte;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo with a behavioural Uart8 peer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    logic clk;
    logic rstN;

    uart_tx_fifo_if #(.DEPTH(16)) bus ();

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    int         errors = 0;
    int         checks = 0;
    int         sentCount = 0;
    int         frames = 0;
    int         frameLen = 4;
    int         busyCnt = 0;
    logic       txEn;
    logic       prevSent = 1'b0;
    logic [7:0] expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Uart8 peer: accepts txStart when enabled, stays busy frameLen+1 cycles, pulses txDone.
    initial begin
        bus.txBusy = 1'b0;
        bus.txDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.txDone = 1'b0;
            if (!rstN) begin
                bus.txBusy = 1'b0;
            end else if (!bus.txBusy) begin
                if (bus.txStart && txEn) begin
                    frames++;
                    if (expQ.size() > 0) begin
                        check("frame_byte", {24'h0, bus.txByte}, {24'h0, expQ.pop_front()});
                    end else begin
                        check("unexpected_frame", {24'h0, bus.txByte}, 32'hFFFF_FFFF);
                    end
                    bus.txBusy = 1'b1;
                    busyCnt    = frameLen;
                end
            end else if (busyCnt == 0) begin
                bus.txBusy = 1'b0;
                bus.txDone = 1'b1;
            end else begin
                busyCnt--;
            end
        end
    end

    // sent monitor: counts pulses and requires each one to last a single cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.sent) begin
                sentCount++;
                check("sent_width", {31'h0, prevSent}, 32'h0);
            end
            prevSent = bus.sent;
        end
    end

    task automatic push(input logic [7:0] b, input bit expected);
        @(negedge clk);
        bus.wrEn   = 1'b1;
        bus.wrData = b;
        if (expected) expQ.push_back(b);
        @(negedge clk);
        bus.wrEn   = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int n = 0;
        while (bus.txBusy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", {31'h0, bus.txBusy}, {31'h0, lvl});
    endtask

    task automatic wait_sent(input int target, input int budget);
        int n = 0;
        while (sentCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sent_timeout", (sentCount >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txStart"},  {31'h0, bus.txStart},  32'h0);
        check({tag, "_txByte"},   {24'h0, bus.txByte},   32'h0);
        check({tag, "_count"},    {27'h0, bus.count},    32'h0);
        check({tag, "_empty"},    {31'h0, bus.empty},    32'h1);
        check({tag, "_full"},     {31'h0, bus.full},     32'h0);
        check({tag, "_overflow"}, {31'h0, bus.overflow}, 32'h0);
        check({tag, "_sent"},     {31'h0, bus.sent},     32'h0);
    endtask

    // Push into an empty FIFO with an idle UART: start appears one cycle later.
    task automatic push_and_start(input logic [7:0] b, input string tag);
        push(b, 1'b1);
        check({tag, "_count_after_push"}, {27'h0, bus.count}, 32'd1);
        check({tag, "_no_start_yet"}, {31'h0, bus.txStart}, 32'h0);
        @(negedge clk);
        check({tag, "_txStart"}, {31'h0, bus.txStart}, 32'h1);
        check({tag, "_txByte"}, {24'h0, bus.txByte}, {24'h0, b});
        check({tag, "_count_after_pop"}, {27'h0, bus.count}, 32'd0);
    endtask

    initial begin
        int base;
        int fr;
        rstN       = 1'b0;
        bus.wrEn   = 1'b0;
        bus.wrData = 8'h00;
        bus.flush  = 1'b0;
        txEn       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rstN = 1'b1;

        // Reset while stuck in START with three bytes queued.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check("midstart_txStart", {31'h0, bus.txStart}, 32'h1);
        check("midstart_count", {27'h0, bus.count}, 32'd3);
        #2 rstN = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rstN = 1'b1;
        txEn = 1'b1;
        base = sentCount;
        push_and_start(8'hA5, "after_rst");
        wait_sent(base + 1, 200);

        // Single byte with an enabled UART.
        base = sentCount;
        fr   = frames;
        push_and_start(8'b1000_1010, "single");
        wait_busy(1'b1, 50);
        @(negedge clk);
        check("single_start_drops", {31'h0, bus.txStart}, 32'h0);
        wait_sent(base + 1, 200);
        repeat (10) @(negedge clk);
        check("single_frames", frames, fr + 1);
        check("single_sent", sentCount, base + 1);

        // UART disabled: txStart must hold until it is enabled.
        txEn = 1'b0;
        base = sentCount;
        fr   = frames;
        push(8'b0111_1010, 1'b1);
        repeat (24) @(negedge clk);
        check("disabled_hold", {31'h0, bus.txStart}, 32'h1);
        check("disabled_byte", {24'h0, bus.txByte}, 32'h7A);
        check("disabled_no_frame", frames, fr);
        txEn = 1'b1;
        wait_busy(1'b1, 50);
        @(negedge clk);
        check("enabled_start_drops", {31'h0, bus.txStart}, 32'h0);
        wait_sent(base + 1, 200);
        repeat (10) @(negedge clk);
        check("enabled_one_frame", frames, fr + 1);

        // Overflow: 17 pushes behind a long frame already in flight.
        frameLen = 40;
        base = sentCount;
        push(8'hEE, 1'b1);
        wait_busy(1'b1, 50);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                check("ovf_full", {31'h0, bus.full}, 32'h1);
                check("ovf_count16", {27'h0, bus.count}, 32'd16);
                check("ovf_not_yet", {31'h0, bus.overflow}, 32'h0);
            end
            bus.wrEn   = 1'b1;
            bus.wrData = i[7:0];
            if (i < 16) expQ.push_back(i[7:0]);
        end
        @(negedge clk);
        bus.wrEn = 1'b0;
        check("ovf_set", {31'h0, bus.overflow}, 32'h1);
        check("ovf_count_kept", {27'h0, bus.count}, 32'd16);
        frameLen = 3;
        wait_sent(base + 17, 2000);
        repeat (10) @(negedge clk);
        check("ovf_sent17", sentCount, base + 17);
        check("ovf_empty", {31'h0, bus.empty}, 32'h1);
        check("ovf_sticky", {31'h0, bus.overflow}, 32'h1);

        // Push coinciding with a pop at count 5, then stream to 40 bytes across wrap.
        frameLen = 2;
        txEn = 1'b0;
        base = sentCount;
        for (int i = 0; i < 6; i++) push(8'h40 + i[7:0], 1'b1);
        check("pp_count5", {27'h0, bus.count}, 32'd5);
        txEn = 1'b1;
        wait_busy(1'b1, 50);
        wait_busy(1'b0, 50);
        bus.wrEn   = 1'b1;
        bus.wrData = 8'h46;
        expQ.push_back(8'h46);
        @(negedge clk);
        bus.wrEn = 1'b0;
        check("pp_count_same", {27'h0, bus.count}, 32'd5);
        check("pp_sent", {31'h0, bus.sent}, 32'h1);
        check("pp_restart", {31'h0, bus.txStart}, 32'h1);
        check("pp_next_byte", {24'h0, bus.txByte}, 32'h41);
        for (int i = 7; i < 40; i++) begin
            push(8'h40 + i[7:0], 1'b1);
            repeat (5) @(negedge clk);
        end
        wait_sent(base + 40, 2000);
        check("pp_empty", {31'h0, bus.empty}, 32'h1);

        // Flush while in START, with a concurrent push that must be discarded.
        txEn = 1'b0;
        push(8'h50, 1'b0);
        push(8'h51, 1'b0);
        push(8'h52, 1'b0);
        push(8'h53, 1'b0);
        check("fs_count3", {27'h0, bus.count}, 32'd3);
        @(negedge clk);
        bus.flush  = 1'b1;
        bus.wrEn   = 1'b1;
        bus.wrData = 8'h99;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.wrEn  = 1'b0;
        check("fs_txStart", {31'h0, bus.txStart}, 32'h0);
        check("fs_count", {27'h0, bus.count}, 32'd0);
        check("fs_overflow", {31'h0, bus.overflow}, 32'h0);
        check("fs_empty", {31'h0, bus.empty}, 32'h1);
        base = sentCount;
        fr   = frames;
        txEn = 1'b1;
        repeat (12) @(negedge clk);
        check("fs_no_sent", sentCount, base);
        check("fs_no_frame", frames, fr);

        // Flush while in WAIT_DONE: current frame completes, queued bytes vanish.
        frameLen = 10;
        base = sentCount;
        fr   = frames;
        push(8'h60, 1'b1);
        wait_busy(1'b1, 50);
        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        check("fw_count2", {27'h0, bus.count}, 32'd2);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fw_count0", {27'h0, bus.count}, 32'd0);
        wait_sent(base + 1, 200);
        repeat (20) @(negedge clk);
        check("fw_one_sent", sentCount, base + 1);
        check("fw_one_frame", frames, fr + 1);
        check("fw_idle", {31'h0, bus.txStart}, 32'h0);

        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
